// File: rtl/handshake_responder_pkg.sv
// Shared constants for the handshake responder and its FIFO.
//   count_width  : width of the completed-transfer counter
//   level_width(): width of an occupancy value able to hold 0..depth inclusive
package handshake_responder_pkg;

   localparam int unsigned count_width = 32;

   // One extra bit over the pointer width so a full FIFO (level == depth) is representable.
   function automatic int unsigned level_width(input int unsigned entries);
      return $clog2(entries) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous active-high reset.
//   clk, rst        : clock (rising edge) and async reset; reset empties the FIFO
//   wr_en, wr_data  : write request and data; ignored while full
//   rd_en           : pop the head entry; ignored while empty
//   rd_data         : head entry (combinational read of storage)
//   level           : current occupancy, 0..depth
//   full, empty     : occupancy flags derived from level
// depth must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo
   import handshake_responder_pkg::*;
#(
   parameter int unsigned data_width = 32,
   parameter int unsigned depth      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [data_width-1:0]         wr_data,
   input  logic                          rd_en,
   output logic [data_width-1:0]         rd_data,
   output logic [level_width(depth)-1:0] level,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned ptr_width = $clog2(depth);
   localparam int unsigned lvl_width = level_width(depth);

   logic [data_width-1:0] mem [depth];
   logic [ptr_width-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ptr_width-1:0]  rd_ptr_q, rd_ptr_d;
   logic [lvl_width-1:0]  level_q, level_d;
   logic                  do_wr, do_rd;

   assign full    = (level_q == lvl_width'(depth));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem[rd_ptr_q];

   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + ptr_width'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + ptr_width'(1);
      end
      unique case ({do_wr, do_rd})
         2'b10:   level_d = level_q + lvl_width'(1);
         2'b01:   level_d = level_q - lvl_width'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; emptiness is carried entirely by the pointers and level.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/handshake_responder.sv
// Responder side of the req/ack dataflow protocol, fed from an internal FIFO.
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   din_valid  : push request
//   din_ready  : FIFO can accept a word (combinational from registered level)
//   din        : push data
//   req        : pull requests, one bit per requester; all must be high to transfer
//   ack        : registered one-cycle transfer pulse
//   dout       : registered data, valid from the edge ack rises, held until next transfer
//   stall      : blocks new acks; pushes are unaffected
//   count      : number of completed pull transfers (wraps)
//   level      : current FIFO occupancy
module handshake_responder
   import handshake_responder_pkg::*;
#(
   parameter int unsigned          data_width    = 32,
   parameter int unsigned          depth         = 16,
   parameter int unsigned          num_req       = 1,
   parameter logic [data_width-1:0] initial_value = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          din_valid,
   output logic                          din_ready,
   input  logic [data_width-1:0]         din,
   input  logic [num_req-1:0]            req,
   output logic                          ack,
   output logic [data_width-1:0]         dout,
   input  logic                          stall,
   output logic [count_width-1:0]        count,
   output logic [level_width(depth)-1:0] level
);

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [data_width-1:0] head;
   logic                  push;
   logic                  pull;

   logic                   ack_q, ack_d;
   logic [data_width-1:0]  dout_q, dout_d;
   logic [count_width-1:0] count_q, count_d;

   // Readiness uses the pre-edge level, so a pop never frees room for a same-edge push.
   assign din_ready = ~fifo_full;
   assign push      = din_valid & din_ready;

   // The ~ack_q guard keeps a requester that drops req on the ack edge from being served twice.
   assign pull = (&req) & ~ack_q & ~stall & ~fifo_empty;

   sync_fifo #(
      .data_width (data_width),
      .depth      (depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (din),
      .rd_en   (pull),
      .rd_data (head),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      ack_d   = 1'b0;
      dout_d  = dout_q;
      count_d = count_q;
      if (pull) begin
         ack_d   = 1'b1;
         dout_d  = head;
         count_d = count_q + count_width'(1);
      end
   end

   // dout is its own register so it stays stable while the FIFO head moves on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q   <= 1'b0;
         dout_q  <= initial_value;
         count_q <= '0;
      end else begin
         ack_q   <= ack_d;
         dout_q  <= dout_d;
         count_q <= count_d;
      end
   end

   assign ack   = ack_q;
   assign dout  = dout_q;
   assign count = count_q;

endmodule
